cic_frame_arbiter: RTL

CIC_FRAME_ARBITER -- requirements
Module: cic_frame_arbiter

---
 rtl/cic_frame_arbiter.sv | 78 +++++++
 1 files changed

// File: rtl/cic_frame_arbiter.sv
// cic_frame_arbiter: round-robin arbiter muxing two framed streams into a CIC decimator, with MAX_LEN truncation and a post-frame settling gap
module cic_frame_arbiter #(
  parameter int DATA_W     = 16,
  parameter int MAX_LEN    = 4096,
  parameter int GAP_CYCLES = 8
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tvalid,
  input  logic              s0_axis_tlast,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tvalid,
  input  logic              s1_axis_tlast,
  output logic              s1_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  input  logic              m_axis_tready,
  output logic              grant_id,
  output logic              busy,
  output logic              frame_done,
  output logic              trunc
);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [GW-1:0] gap_q;
  logic          grant_q, last_q;
  logic          in_valid, in_last, at_max, accept;
  assign in_valid       = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
  assign in_last        = grant_q ? s1_axis_tlast : s0_axis_tlast;
  assign at_max         = cnt_q == CW'(MAX_LEN - 1);
  assign m_axis_tvalid  = state_q == GRANT && in_valid;
  assign m_axis_tdata   = grant_q ? s1_axis_tdata : s0_axis_tdata;
  assign m_axis_tlast   = m_axis_tvalid && (in_last || at_max);
  assign m_axis_tuser   = grant_q;
  assign s0_axis_tready = state_q == GRANT && !grant_q && m_axis_tready;
  assign s1_axis_tready = state_q == GRANT && grant_q && m_axis_tready;
  assign accept         = m_axis_tvalid && m_axis_tready;
  assign frame_done     = accept && (in_last || at_max);
  assign trunc          = accept && at_max && !in_last;
  assign busy           = state_q != IDLE;
  assign grant_id       = grant_q;
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (s0_axis_tvalid || s1_axis_tvalid) begin
          grant_q <= (s0_axis_tvalid && s1_axis_tvalid) ? !last_q : s1_axis_tvalid;
          state_q <= GRANT;
        end
        GRANT: if (accept) begin
          if (frame_done) begin
            cnt_q   <= '0;
            last_q  <= grant_q;
            gap_q   <= GW'(GAP_CYCLES - 1);
            state_q <= GAP_CYCLES == 0 ? IDLE : GAP;
          end else cnt_q <= cnt_q + CW'(1);
        end
        GAP: begin
          gap_q <= gap_q - GW'(1);
          if (gap_q == '0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
